// File: rtl/tg_mux_arbiter_if.sv
// Request/data bundle and registered mux-control outputs shared between
// the requesting sources and the transmission-gate mux arbiter.
interface tg_mux_arbiter_if #(
  parameter int unsigned W = 8
);
  logic [3:0]     req;
  logic [4*W-1:0] din;
  logic [3:0]     gnt;
  logic [1:0]     sel;
  logic           en;
  logic [W-1:0]   dout;
  logic           valid;

  modport master (
    output req, din,
    input  gnt, sel, en, dout, valid
  );

  modport slave (
    input  req, din,
    output gnt, sel, en, dout, valid
  );
endinterface

// File: rtl/tg_mux_arbiter.sv
// Round-robin arbiter for a shared 4:1 transmission-gate mux with
// break-before-make dead time between owners and a registered data path.
module tg_mux_arbiter #(
  parameter int unsigned W        = 8,
  parameter int unsigned HOLD_MAX = 8,
  parameter int unsigned DEAD     = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  tg_mux_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_BREAK = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic [1:0]   ptr_q,   ptr_d;
  logic [1:0]   sel_q,   sel_d;
  logic [3:0]   gnt_q,   gnt_d;
  logic         en_q,    en_d;
  logic [7:0]   cnt_q,   cnt_d;
  logic [3:0]   dcnt_q,  dcnt_d;
  logic [W-1:0] dout_q,  dout_d;
  logic         valid_q, valid_d;

  logic         win_found;
  logic [1:0]   win_idx;
  logic [1:0]   cand;

  // Search ptr+1 .. ptr+4 (mod 4); the 2-bit add wraps, so the last
  // candidate is the previous owner itself.
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr_q;
    cand      = ptr_q;
    for (int unsigned k = 1; k <= 4; k++) begin
      cand = ptr_q + 2'(k);
      if (!win_found && bus.req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    en_d    = en_q;
    cnt_d   = cnt_q;
    dcnt_d  = dcnt_q;
    dout_d  = en_q ? bus.din[int'(sel_q)*W +: W] : '0;
    valid_d = en_q;

    case (state_q)
      S_IDLE: begin
        gnt_d = '0;
        en_d  = 1'b0;
        if (win_found) begin
          state_d = S_GRANT;
          ptr_d   = win_idx;
          sel_d   = win_idx;
          gnt_d   = 4'b0001 << win_idx;
          en_d    = 1'b1;
          cnt_d   = '0;
        end
      end

      S_GRANT: begin
        if (!bus.req[sel_q] || (cnt_q == 8'(HOLD_MAX - 1))) begin
          state_d = S_BREAK;
          gnt_d   = '0;
          en_d    = 1'b0;
          dcnt_d  = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      S_BREAK: begin
        gnt_d = '0;
        en_d  = 1'b0;
        if (dcnt_q == 4'(DEAD - 1)) begin
          if (win_found) begin
            state_d = S_GRANT;
            ptr_d   = win_idx;
            sel_d   = win_idx;
            gnt_d   = 4'b0001 << win_idx;
            en_d    = 1'b1;
            cnt_d   = '0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          dcnt_d = dcnt_q + 4'd1;
        end
      end

      default: begin
        state_d = S_IDLE;
        gnt_d   = '0;
        en_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= 2'd3;
      sel_q   <= '0;
      gnt_q   <= '0;
      en_q    <= 1'b0;
      cnt_q   <= '0;
      dcnt_q  <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      en_q    <= en_d;
      cnt_q   <= cnt_d;
      dcnt_q  <= dcnt_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
    end
  end

  assign bus.gnt   = gnt_q;
  assign bus.sel   = sel_q;
  assign bus.en    = en_q;
  assign bus.dout  = dout_q;
  assign bus.valid = valid_q;

endmodule

// File: tb/tb_tg_mux_arbiter.sv
// Bench for tg_mux_arbiter: two parameterisations share one stimulus stream
// and are checked against an ownership-level reference model every cycle.
module tb_tg_mux_arbiter;
  localparam int W = 8;

  logic           clk;
  logic           rst_n;
  logic [3:0]     req;
  logic [4*W-1:0] din;

  tg_mux_arbiter_if #(.W(W)) ifa ();
  tg_mux_arbiter_if #(.W(W)) ifb ();

  assign ifa.req = req;
  assign ifa.din = din;
  assign ifb.req = req;
  assign ifb.din = din;

  tg_mux_arbiter #(.W(W), .HOLD_MAX(8), .DEAD(1)) u_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa)
  );

  tg_mux_arbiter #(.W(W), .HOLD_MAX(2), .DEAD(3)) u_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // owner < 0: nobody granted; gap > 0: cycles spent in dead time so far
  typedef struct {
    int           owner;
    int           held;
    int           gap;
    int           last;
    logic [1:0]   sel;
    logic         en;
    logic         valid;
    logic [W-1:0] dout;
  } mdl_t;

  typedef struct {
    logic         rst_n;
    logic [3:0]   req;
    logic [3:0]   gnt;
    logic [1:0]   sel;
    logic         en;
    logic         valid;
    logic [W-1:0] dout;
  } vec_t;

  mdl_t ma, mb;
  vec_t tbl[12];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic mdl_t mdl_reset();
    mdl_t m;
    m.owner = -1; m.held = 0; m.gap = 0; m.last = 3;
    m.sel = 2'd0; m.en = 1'b0; m.valid = 1'b0; m.dout = '0;
    return m;
  endfunction

  function automatic mdl_t mstep(mdl_t m, int hold_max, int dead, logic rs,
                                 logic [3:0] r, logic [4*W-1:0] d);
    mdl_t n;
    bit   arb;
    if (!rs) return mdl_reset();
    n       = m;
    arb     = 1'b0;
    n.valid = m.en;
    n.dout  = m.en ? d[int'(m.sel)*W +: W] : '0;
    if (m.owner >= 0) begin
      if (!r[m.owner] || m.held == hold_max) begin
        n.owner = -1;
        n.gap   = 1;
      end else begin
        n.held = m.held + 1;
      end
    end else if (m.gap > 0) begin
      if (m.gap >= dead) arb = 1'b1;
      else n.gap = m.gap + 1;
    end else begin
      arb = 1'b1;
    end
    if (arb) begin
      n.gap   = 0;
      n.owner = -1;
      for (int k = 1; k <= 4; k++) begin
        int c;
        c = (m.last + k) % 4;
        if (n.owner < 0 && r[c]) begin
          n.owner = c;
          n.last  = c;
          n.held  = 1;
          n.sel   = 2'(c);
        end
      end
    end
    n.en = (n.owner >= 0);
    return n;
  endfunction

  function automatic logic [3:0] mgnt(mdl_t m);
    return (m.owner >= 0) ? 4'(1 << m.owner) : 4'b0000;
  endfunction

  function automatic logic [63:0] pk(logic [3:0] g, logic [1:0] s, logic e,
                                     logic v, logic [W-1:0] d);
    return 64'({g, s, e, v, d});
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    ma = mstep(ma, 8, 1, rst_n, req, din);
    mb = mstep(mb, 2, 3, rst_n, req, din);
    #1;
    chk("model_a", pk(ifa.gnt, ifa.sel, ifa.en, ifa.valid, ifa.dout),
                   pk(mgnt(ma), ma.sel, ma.en, ma.valid, ma.dout));
    chk("model_b", pk(ifb.gnt, ifb.sel, ifb.en, ifb.valid, ifb.dout),
                   pk(mgnt(mb), mb.sel, mb.en, mb.valid, mb.dout));
    chk("inv_a", {62'b0, $onehot0(ifa.gnt), ifa.en == (|ifa.gnt)}, 64'd3);
    chk("inv_b", {62'b0, $onehot0(ifb.gnt), ifb.en == (|ifb.gnt)}, 64'd3);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    ma    = mdl_reset();
    mb    = mdl_reset();
    rst_n = 1'b0;
    req   = 4'hF;
    din   = {8'hC3, 8'hA5, 8'h5A, 8'h3C};

    //          rst   req      gnt      sel  en  val  dout
    tbl[0]  = '{1'b0, 4'hF,    4'b0000, 2'd0, 0, 0, 8'h00};
    tbl[1]  = '{1'b0, 4'hF,    4'b0000, 2'd0, 0, 0, 8'h00};
    tbl[2]  = '{1'b0, 4'hF,    4'b0000, 2'd0, 0, 0, 8'h00};
    tbl[3]  = '{1'b1, 4'hF,    4'b0001, 2'd0, 1, 0, 8'h00};
    tbl[4]  = '{1'b1, 4'h0,    4'b0000, 2'd0, 0, 1, 8'h3C};
    tbl[5]  = '{1'b1, 4'h0,    4'b0000, 2'd0, 0, 0, 8'h00};
    tbl[6]  = '{1'b1, 4'b0100, 4'b0100, 2'd2, 1, 0, 8'h00};
    tbl[7]  = '{1'b1, 4'b0100, 4'b0100, 2'd2, 1, 1, 8'hA5};
    tbl[8]  = '{1'b1, 4'b0100, 4'b0100, 2'd2, 1, 1, 8'hA5};
    tbl[9]  = '{1'b1, 4'h0,    4'b0000, 2'd2, 0, 1, 8'hA5};
    tbl[10] = '{1'b1, 4'h0,    4'b0000, 2'd2, 0, 0, 8'h00};
    tbl[11] = '{1'b1, 4'h0,    4'b0000, 2'd2, 0, 0, 8'h00};

    for (int i = 0; i < 12; i++) begin
      rst_n = tbl[i].rst_n;
      req   = tbl[i].req;
      step();
      chk($sformatf("table[%0d]", i),
          pk(ifa.gnt, ifa.sel, ifa.en, ifa.valid, ifa.dout),
          pk(tbl[i].gnt, tbl[i].sel, tbl[i].en, tbl[i].valid, tbl[i].dout));
    end

    // Fairness: all request, owners 0,1,2,3,0 for 8 cycles each, 1-cycle gap
    do_reset();
    req = 4'hF;
    for (int i = 0; i < 45; i++) begin
      step();
      chk("fair_gnt", 64'(ifa.gnt),
          (i % 9 < 8) ? 64'(1 << ((i / 9) % 4)) : 64'd0);
    end

    // Skip order: requesters 0 and 2 only alternate
    do_reset();
    req = 4'b0101;
    for (int i = 0; i < 27; i++) begin
      step();
      chk("skip_gnt", 64'(ifa.gnt),
          (i % 9 < 8) ? 64'(1 << (((i / 9) % 2) * 2)) : 64'd0);
    end

    // Reset during owner-2 grant, then requester 1 wins from ptr=3
    do_reset();
    req = 4'b0100;
    step();
    step();
    step();
    chk("mid_pre_gnt", 64'(ifa.gnt), 64'(4'b0100));
    rst_n = 1'b0;
    req   = 4'b0110;
    step();
    chk("mid_rst_out", pk(ifa.gnt, ifa.sel, ifa.en, ifa.valid, ifa.dout), 64'd0);
    rst_n = 1'b1;
    step();
    chk("mid_post_gnt", pk(ifa.gnt, ifa.sel, ifa.en, ifa.valid, ifa.dout),
        pk(4'b0010, 2'd1, 1'b1, 1'b0, 8'h00));

    // Long dead time on the second instance: 2 grant cycles, 3 gap cycles
    do_reset();
    req = 4'b0011;
    for (int i = 0; i < 25; i++) begin
      step();
      chk("dead_gnt", 64'(ifb.gnt),
          (i % 5 < 2) ? (((i / 5) % 2 == 1) ? 64'd2 : 64'd1) : 64'd0);
      chk("dead_valid", 64'(ifb.valid), (i % 5 == 1 || i % 5 == 2) ? 64'd1 : 64'd0);
    end

    // Random traffic with occasional resets
    do_reset();
    for (int i = 0; i < 800; i++) begin
      rst_n = ($urandom_range(0, 60) != 0);
      if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
      din = $urandom;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
